div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 31 +++
 rtl/div_iter_step.sv | 29 ++
 rtl/div_unit.sv | 179 +++++++++++++++++
 tb/tb_div_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared core-wide constants, divide op encodings and the divider state type.
// Also holds the conditional two's-complement helper used for sign handling.
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 5;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // Two's-complement negate modulo 2^XLEN when en is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
        logic [XLEN-1:0] r;
        if (en) begin
            r = ~v + XLEN'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_iter_step
    import div_unit_pkg::*;
(
    input  logic [XLEN:0]   rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);

    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] dvs_ext_s;

    // Compare/subtract at XLEN+1 bits so the shifted remainder never overflows.
    always_comb begin
        rem_sh_s  = {rem_in[XLEN-1:0], dvd_msb};
        dvs_ext_s = {1'b0, divisor};
        if (rem_sh_s >= dvs_ext_s) begin
            rem_out = rem_sh_s - dvs_ext_s;
            q_bit   = 1'b1;
        end else begin
            rem_out = rem_sh_s;
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: one quotient bit per clock, fast
// path for divide-by-zero and signed overflow, registered write-back triple.
module div_unit
    import div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [RA_W-1:0] rd_in,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [RA_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data
);

    div_state_e      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            done_q, done_d;
    logic            wb_we_q, wb_we_d;
    logic [RA_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic [XLEN:0]   step_rem_s;
    logic            step_q_s;
    logic            signed_s;
    logic            div0_s;
    logic            ovf_s;

    div_iter_step u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[XLEN-1]),
        .divisor (dvs_q),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Next-state and datapath: accept, iterate, then register the fixed-up result.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        done_d    = 1'b0;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;

        signed_s = ~op[0];
        div0_s   = (rs2_val == {XLEN{1'b0}});
        ovf_s    = signed_s && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                            && (rs2_val == {XLEN{1'b1}});

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    rd_d  = rd_in;
                    cnt_d = {CNT_W{1'b0}};
                    dvs_d = neg_if(rs2_val, signed_s && rs2_val[XLEN-1]);
                    // Special cases preload the final quotient/remainder and skip fix-up.
                    if (div0_s) begin
                        dvd_d   = {XLEN{1'b1}};
                        rem_d   = {1'b0, rs1_val};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end else if (ovf_s) begin
                        dvd_d   = {1'b1, {(XLEN-1){1'b0}}};
                        rem_d   = {(XLEN+1){1'b0}};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        dvd_d   = neg_if(rs1_val, signed_s && rs1_val[XLEN-1]);
                        rem_d   = {(XLEN+1){1'b0}};
                        qneg_d  = signed_s && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                        rneg_d  = signed_s && rs1_val[XLEN-1];
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = step_rem_s;
                dvd_d = {dvd_q[XLEN-2:0], step_q_s};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                wb_rd_d = rd_q;
                wb_we_d = (rd_q != {RA_W{1'b0}});
                if (op_q[1]) begin
                    wb_data_d = neg_if(rem_q[XLEN-1:0], rneg_q);
                end else begin
                    wb_data_d = neg_if(dvd_q, qneg_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (kill) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            wb_we_d   = 1'b0;
            wb_rd_d   = wb_rd_q;
            wb_data_d = wb_data_q;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            rd_q      <= {RA_W{1'b0}};
            dvd_q     <= {XLEN{1'b0}};
            dvs_q     <= {XLEN{1'b0}};
            rem_q     <= {(XLEN+1){1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= {RA_W{1'b0}};
            wb_data_q <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            done_q    <= done_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == CALC) || (state_q == DONE);
    assign done    = done_q;
    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with hand-computed quotients,
// remainders, latencies and control-rule checks.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        kill;
    logic        ready;
    logic        busy;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_total;
    int n_pass;

    div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .kill    (kill),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request; returns just after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_data, input int exp_lat);
        int lat;
        issue(o, a, b, rd);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 60);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        check({tag, "_we"}, {31'd0, wb_we}, {31'd0, (rd != 5'd0)});
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, wb_data, exp_data);
    endtask

    initial begin
        int dcount;
        int first_d;
        int second_d;
        int n;
        n_total  = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        kill     = 1'b0;
        op       = 2'b00;
        rs1_val  = 32'd0;
        rs2_val  = 32'd0;
        rd_in    = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, wb_we}, 32'd0);
        check("rst_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_data", wb_data, 32'd0);
        rst = 1'b0;

        run_op("divu", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run_op("remu", 2'b11, 32'd100, 32'd7, 5'd5, 32'd2, 33);
        run_op("div_neg", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
        run_op("rem_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
        run_op("div_z", 2'b00, 32'd1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
        run_op("rem_z", 2'b10, 32'd1234, 32'd0, 5'd7, 32'd1234, 1);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1);

        // kill together with start in IDLE drops the request
        op = 2'b01; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd9;
        start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check("kill_idle_ready", {31'd0, ready}, 32'd1);
        check("kill_idle_busy", {31'd0, busy}, 32'd0);

        // kill mid-CALC
        issue(2'b01, 32'd1000, 32'd3, 5'd4);
        repeat (10) @(posedge clk);
        #1;
        check("kill_busy_before", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_ready", {31'd0, ready}, 32'd1);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || wb_we) dcount++;
            @(posedge clk);
            #1;
        end
        check("kill_no_wb", dcount, 32'd0);
        run_op("after_kill", 2'b01, 32'd9, 32'd3, 5'd10, 32'd3, 33);

        // rst mid-CALC clears everything
        issue(2'b01, 32'd77, 32'd7, 5'd11);
        repeat (5) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_mid_data", wb_data, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);

        run_op("rd0", 2'b01, 32'd8, 32'd2, 5'd0, 32'd4, 33);

        // start held high: one accept per 34 cycles, ready/busy exclusive
        op = 2'b01; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3;
        start    = 1'b1;
        dcount   = 0;
        first_d  = 0;
        second_d = 0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            check("rdy_busy_excl", {31'd0, ready & busy}, 32'd0);
            if (done) begin
                dcount++;
                if (dcount == 1) first_d = i;
                else if (dcount == 2) second_d = i;
            end
        end
        start = 1'b0;
        check("hold_dcount", dcount, 32'd2);
        check("hold_first", first_d, 32'd34);
        check("hold_gap", second_d - first_d, 32'd34);
        check("hold_data", wb_data, 32'd14);
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", {31'd0, done}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
